serial_adder_engine: RTL and testbench
======================================

# serial_adder_engine

Bit-serial N-bit adder that drives a single full-adder cell and a carry flip-flop over WIDTH cycles, LSB first. It accepts operand pairs on a valid/ready input handshake and returns sum, carry-out and signed overflow on a valid/ready output handshake. It sits in the arithmetic datapath as the area-minimal alternative to a parallel ripple adder, and it reuses the one-bit full-adder equations.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range ≥ 2
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands a_in/b_in/cin_in are valid
- in_ready  out  1  engine can accept operands; high only in IDLE
- a_in  in  WIDTH  operand A, unsigned or two's complement
- b_in  in  WIDTH  operand B
- cin_in  in  1  carry into bit 0
- out_valid  out  1  result valid; high only in DONE
- out_ready  in  1  consumer accepts the result
- sum_out  out  WIDTH  (a_in + b_in + cin_in) mod 2^WIDTH
- cout_out  out  1  carry out of bit WIDTH-1
- ovf_out  out  1  signed overflow: carry into MSB XOR carry out of MSB
- busy  out  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: in_ready=1.
  - On in_valid & in_ready, capture a_in and b_in into shift registers A and B, and cin_in into carry register C.
  - Clear bit counter cnt (width $clog2(WIDTH)) to 0 and go to RUN.
- RUN, one bit per cycle:
  - s = A[0]^B[0]^C
  - C <= (A[0]&B[0]) | (C&(A[0]^B[0]))
  - A and B shift right by 1.
  - s shifts into the MSB of the sum shift register S, which shifts right.
  - cnt increments.
  - When cnt == WIDTH-1 (bit WIDTH-1 is being processed):
    - copy C (the carry into the MSB) to ovf-capture.
    - load result registers: sum_out <= final S, cout_out <= new carry, ovf_out <= carry-in-to-MSB XOR new carry.
    - go to DONE.
- DONE: out_valid=1. sum_out, cout_out and ovf_out are held stable. On out_valid & out_ready, go to IDLE.
- in_valid is ignored outside IDLE. Operands must be held by the source only until the accepting edge.
- Result registers keep their last value through IDLE and RUN. They change only on the RUN→DONE edge.
- in_ready = (state==IDLE) and out_valid = (state==DONE), both decoded directly from the state register. There is no combinational path from in_valid or out_ready to any output.
- Carry-chain arithmetic is modulo 2^WIDTH. Unsigned overflow is reported on cout_out, signed overflow on ovf_out.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, in_ready=1, out_valid=0, busy=0, sum_out=0, cout_out=0, ovf_out=0. A, B, C, S and cnt are cleared.
- Reset mid-RUN or mid-DONE: the operation and any pending result are discarded. No out_valid is produced for that operation.
- Accept edge E0. RUN occupies edges E1..EWIDTH. out_valid is high from after EWIDTH.
  - Latency: WIDTH cycles from accept to out_valid.
- With out_ready tied high, DONE lasts 1 cycle and in_ready is high again one cycle later.
  - Minimum initiation interval: WIDTH+2 cycles per operation.
- out_ready low in DONE stalls indefinitely with the result held. A new in_valid is not accepted until the engine returns to IDLE.
- in_valid and out_ready arriving in the same cycle cannot be served together: DONE→IDLE takes one edge, and the accept happens on a later edge.

## Test plan
- Reset behaviour: assert rst_n=0 during RUN of 8'hFF+8'h01 → outputs immediately 0 and in_ready=1. After release, no out_valid appears.
- Basic add (WIDTH=8): a=8'h35, b=8'h4A, cin=0 → out_valid exactly 8 cycles after accept, with sum=8'h7F, cout=0, ovf=0.
- Full carry ripple:
  - a=8'hFF, b=8'h00, cin=1 → sum=8'h00, cout=1, ovf=0.
  - a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1, ovf=0.
- Signed overflow:
  - a=8'h7F, b=8'h01, cin=0 → sum=8'h80, cout=0, ovf=1.
  - a=8'h80, b=8'h80, cin=0 → sum=8'h00, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid and the result stay stable, in_ready stays 0, and a pulsed in_valid with new operands is ignored. Then raise out_ready → one handshake, and in_ready returns on the next cycle.
- Back-to-back: in_valid and out_ready held high, source presenting i={a,b,cin} for i=0..9 (the exhaustive 3-bit pattern placed in the LSBs) → each result equals a+b+cin, and accepts are spaced exactly WIDTH+2 cycles apart.

Source files
------------

// File: rtl/serial_adder_engine_if.sv
// Handshake bundle for the bit-serial adder: operand request channel,
// result response channel and the busy status flag.
interface serial_adder_engine_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum_out;
    logic             cout_out;
    logic             ovf_out;
    logic             busy;

    // Engine side: consumes operands, produces results.
    modport slave (
        input  in_valid, a_in, b_in, cin_in, out_ready,
        output in_ready, out_valid, sum_out, cout_out, ovf_out, busy
    );

    // Client side: produces operands, consumes results.
    modport master (
        output in_valid, a_in, b_in, cin_in, out_ready,
        input  in_ready, out_valid, sum_out, cout_out, ovf_out, busy
    );
endinterface

// File: rtl/serial_adder_engine.sv
// Bit-serial adder: one full-adder cell plus a carry flop, walked LSB first
// over WIDTH cycles. Returns sum, unsigned carry-out and signed overflow.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for operands, in_ready high
// RUN    | one bit of the sum produced per cycle, cnt tracks the bit
// DONE   | result presented with out_valid, held until out_ready
module serial_adder_engine #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_adder_engine_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic [WIDTH-1:0] r_s;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic             w_bit;
    logic             w_carry;
    logic [WIDTH-1:0] w_s_nxt;

    assign w_accept = (r_state == S_IDLE) && bus.in_valid;
    assign w_last   = (r_state == S_RUN) && (r_cnt == LAST_BIT);

    // Single full-adder cell working on the current LSBs.
    assign w_bit   = r_a[0] ^ r_b[0] ^ r_c;
    assign w_carry = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));
    assign w_s_nxt = {w_bit, r_s[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.in_valid)  w_state_nxt = S_RUN;
            S_RUN:  if (w_last)        w_state_nxt = S_DONE;
            S_DONE: if (bus.out_ready) w_state_nxt = S_IDLE;
            default:                   w_state_nxt = S_IDLE;
        endcase
    end

    // Operand shifters, carry flop, sum shifter and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= 1'b0;
            r_s   <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_a   <= bus.a_in;
            r_b   <= bus.b_in;
            r_c   <= bus.cin_in;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_a   <= {1'b0, r_a[WIDTH-1:1]};
            r_b   <= {1'b0, r_b[WIDTH-1:1]};
            r_c   <= w_carry;
            r_s   <= w_s_nxt;
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Result registers change only on the RUN->DONE edge; r_c there is the
    // carry into the MSB, so XOR with the new carry gives signed overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_last) begin
            r_sum  <= w_s_nxt;
            r_cout <= w_carry;
            r_ovf  <= r_c ^ w_carry;
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.sum_out   = r_sum;
    assign bus.cout_out  = r_cout;
    assign bus.ovf_out   = r_ovf;
endmodule

// File: tb/tb_serial_adder_engine.sv
// Directed bench for serial_adder_engine at WIDTH=8.
module tb_serial_adder_engine;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    int   cyc;

    serial_adder_engine_if #(.WIDTH(W)) u_if ();

    serial_adder_engine #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation with out_ready high; checks latency and result.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic [W-1:0] esum, input logic ecout,
                          input logic eovf);
        int n;
        @(negedge clk);
        chk({name, " in_ready"}, 32'(u_if.in_ready), 32'd1);
        u_if.a_in     = a;
        u_if.b_in     = b;
        u_if.cin_in   = cin;
        u_if.in_valid = 1'b1;
        @(negedge clk);
        u_if.in_valid = 1'b0;
        u_if.a_in     = '0;
        u_if.b_in     = '0;
        u_if.cin_in   = 1'b0;
        n = 0;
        while (!u_if.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, " latency"}, 32'(n), 32'd8);
        chk({name, " sum"},  32'(u_if.sum_out),  32'(esum));
        chk({name, " cout"}, 32'(u_if.cout_out), 32'(ecout));
        chk({name, " ovf"},  32'(u_if.ovf_out),  32'(eovf));
    endtask

    vec_t vecs[8];

    initial begin
        int n;
        int seen;
        int acc_prev;
        logic [W-1:0] held;
        logic [W:0]   full;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic         ec;

        vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0};
        vecs[6] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        n_pass = 0;
        n_total = 0;
        cyc = 0;
        rst_n = 1'b0;
        u_if.in_valid  = 1'b0;
        u_if.out_ready = 1'b1;
        u_if.a_in      = '0;
        u_if.b_in      = '0;
        u_if.cin_in    = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst in_ready",  32'(u_if.in_ready),  32'd1);
        chk("rst out_valid", 32'(u_if.out_valid), 32'd0);
        chk("rst busy",      32'(u_if.busy),      32'd0);
        chk("rst sum",       32'(u_if.sum_out),   32'd0);
        chk("rst cout",      32'(u_if.cout_out),  32'd0);
        chk("rst ovf",       32'(u_if.ovf_out),   32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                   vecs[i].sum, vecs[i].cout, vecs[i].ovf);
        end

        // Reset in the middle of RUN discards the operation.
        @(negedge clk);
        u_if.a_in = 8'hFF; u_if.b_in = 8'h01; u_if.cin_in = 1'b0;
        u_if.in_valid = 1'b1;
        @(negedge clk);
        u_if.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrun busy", 32'(u_if.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst in_ready",  32'(u_if.in_ready),  32'd1);
        chk("midrst out_valid", 32'(u_if.out_valid), 32'd0);
        chk("midrst busy",      32'(u_if.busy),      32'd0);
        chk("midrst sum",       32'(u_if.sum_out),   32'd0);
        chk("midrst cout",      32'(u_if.cout_out),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (u_if.out_valid) seen++;
        end
        chk("midrst no out_valid", 32'(seen), 32'd0);

        // Backpressure: result held through a 5-cycle stall, new request ignored.
        u_if.out_ready = 1'b0;
        run_op("bp", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
        held = u_if.sum_out;
        for (int k = 0; k < 5; k++) begin
            u_if.in_valid = (k == 2);
            u_if.a_in = 8'h01; u_if.b_in = 8'h01;
            @(negedge clk);
            chk($sformatf("bp out_valid %0d", k), 32'(u_if.out_valid), 32'd1);
            chk($sformatf("bp in_ready %0d", k),  32'(u_if.in_ready),  32'd0);
            chk($sformatf("bp sum %0d", k),       32'(u_if.sum_out),   32'(held));
        end
        u_if.in_valid = 1'b0;
        u_if.out_ready = 1'b1;
        @(negedge clk);
        chk("bp release out_valid", 32'(u_if.out_valid), 32'd0);
        chk("bp release in_ready",  32'(u_if.in_ready),  32'd1);
        chk("bp release busy",      32'(u_if.busy),      32'd0);
        chk("bp sum held in idle",  32'(u_if.sum_out),   32'h46);
        repeat (2) @(negedge clk);
        chk("bp pulse ignored", 32'(u_if.busy), 32'd0);

        // Back-to-back with in_valid and out_ready held high.
        acc_prev = -1;
        u_if.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ea = W'((i >> 2) & 1);
            eb = W'((i >> 1) & 1);
            ec = 1'(i & 1);
            u_if.a_in = ea; u_if.b_in = eb; u_if.cin_in = ec;
            n = 0;
            while (!u_if.in_ready && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (n >= 40) chk($sformatf("b2b accept timeout %0d", i), 32'd0, 32'd1);
            if (acc_prev >= 0) chk($sformatf("b2b spacing %0d", i), 32'(cyc - acc_prev), 32'd10);
            acc_prev = cyc;
            @(negedge clk);
            n = 0;
            while (!u_if.out_valid && n < 40) begin
                @(negedge clk);
                n++;
            end
            full = {1'b0, ea} + {1'b0, eb} + {{W{1'b0}}, ec};
            chk($sformatf("b2b sum %0d", i),  32'(u_if.sum_out),  32'(full[W-1:0]));
            chk($sformatf("b2b cout %0d", i), 32'(u_if.cout_out), 32'(full[W]));
            chk($sformatf("b2b ovf %0d", i),  32'(u_if.ovf_out),  32'd0);
        end
        u_if.in_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
